// File: rtl/systolic_pkg.sv
// Shared defaults, FSM state encoding and matrix-select constants for the
// systolic operand skew feeder.
package systolic_pkg;
    localparam int N_DEFAULT  = 4;
    localparam int DW_DEFAULT = 32;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        STREAM,
        DRAIN,
        FIN
    } state_e;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/skew_lane_mux.sv
// One skewed lane: picks element (t - lane) of a row/column vector, or 0
// when that offset falls outside the N-element window.
module skew_lane_mux #(
    parameter int N  = 4,
    parameter int DW = 32,
    parameter int TW = 4
) (
    input  logic [TW-1:0]         lane_i,
    input  logic [TW-1:0]         t_i,
    input  logic [N-1:0][DW-1:0]  vec_i,
    output logic [DW-1:0]         elem_o
);
    localparam int LW = (N > 1) ? $clog2(N) : 1;

    logic [TW-1:0] off;
    assign off = t_i - lane_i;

    always_comb begin
        elem_o = '0;
        if ((t_i >= lane_i) && (off < TW'(N))) begin
            elem_o = vec_i[off[LW-1:0]];
        end
    end
endmodule

// File: rtl/systolic_skew_feeder.sv
// Stages matrices A/B and streams them diagonally skewed into a systolic array.
// Optional SKEW_FEEDER_DBUF_EN adds shadow banks so loads can overlap a pass.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int N            = N_DEFAULT,
    parameter int DW           = DW_DEFAULT,
    parameter int DRAIN_CYCLES = 4,
    localparam int LW          = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [LW-1:0]   wr_row,
    input  logic [LW-1:0]   wr_col,
    input  logic [DW-1:0]   wr_data,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            arr_rst,
    output logic [N*DW-1:0] west_out,
    output logic [N*DW-1:0] north_out
);
    localparam int CNT_MAX = (2 * N > DRAIN_CYCLES) ? 2 * N : DRAIN_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] STREAM_LAST = CW'(2 * N - 1);
    localparam logic [CW-1:0] DRAIN_LAST  = CW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    typedef logic [N-1:0][N-1:0][DW-1:0] mat_t;

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [N-1:0][DW-1:0]   west_q, west_d, north_q, north_d;
    logic [N-1:0][DW-1:0]   west_mux, north_mux;
    mat_t                   a_q, b_q, b_col;
    logic                   accept;

    assign accept = (state_q == IDLE) && start;

`ifdef SKEW_FEEDER_DBUF_EN
    mat_t a_sh_q, a_sh_d, b_sh_q, b_sh_d;

    always_comb begin
        a_sh_d = a_sh_q;
        b_sh_d = b_sh_q;
        if (wr_en) begin
            if (wr_sel == SEL_A) a_sh_d[wr_row][wr_col] = wr_data;
            else if (wr_sel == SEL_B) b_sh_d[wr_row][wr_col] = wr_data;
        end
    end

    // Copy uses the post-write shadow so a write coinciding with start is included
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q <= '0;
            b_sh_q <= '0;
            a_q    <= '0;
            b_q    <= '0;
        end else begin
            a_sh_q <= a_sh_d;
            b_sh_q <= b_sh_d;
            if (accept) begin
                a_q <= a_sh_d;
                b_q <= b_sh_d;
            end
        end
    end
`else
    mat_t a_d, b_d;

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (wr_en && (state_q == IDLE)) begin
            if (wr_sel == SEL_A) a_d[wr_row][wr_col] = wr_data;
            else if (wr_sel == SEL_B) b_d[wr_row][wr_col] = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end
`endif

    for (genvar i = 0; i < N; i++) begin : g_lane
        for (genvar r = 0; r < N; r++) begin : g_col
            assign b_col[i][r] = b_q[r][i];
        end
        skew_lane_mux #(.N(N), .DW(DW), .TW(CW)) u_west (
            .lane_i (CW'(i)),
            .t_i    (cnt_q),
            .vec_i  (a_q[i]),
            .elem_o (west_mux[i])
        );
        skew_lane_mux #(.N(N), .DW(DW), .TW(CW)) u_north (
            .lane_i (CW'(i)),
            .t_i    (cnt_q),
            .vec_i  (b_col[i]),
            .elem_o (north_mux[i])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        west_d  = '0;
        north_d = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CLR;
                    cnt_d   = '0;
                end
            end
            CLR: begin
                state_d = STREAM;
                west_d  = west_mux;
                north_d = north_mux;
                cnt_d   = cnt_q + CW'(1);
            end
            // cnt_q is the step being registered for the next cycle
            STREAM: begin
                if (cnt_q == STREAM_LAST) begin
                    cnt_d   = '0;
                    state_d = (DRAIN_CYCLES == 0) ? FIN : DRAIN;
                end else begin
                    west_d  = west_mux;
                    north_d = north_mux;
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) state_d = FIN;
                else cnt_d = cnt_q + CW'(1);
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            west_q  <= '0;
            north_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            west_q  <= west_d;
            north_q <= north_d;
        end
    end

    assign busy      = (state_q == CLR) || (state_q == STREAM) || (state_q == DRAIN);
    assign done      = (state_q == FIN);
    assign arr_rst   = (state_q == CLR);
    assign west_out  = west_q;
    assign north_out = north_q;
endmodule

// File: doc/systolic_skew_feeder.md
Name: systolic_skew_feeder

Overview:
- Operand staging and skew stage directly upstream of the 4x4 systolic_array.
- Holds matrix A (west operands) and matrix B (north operands), loaded element by element.
- On start, emits diagonally skewed per-lane streams on the array's west and north inputs.
- Drives the array's accumulator clear and reports completion. Removes hand-built skew sequencing from the top level and benches.

Parameters:
- N, 4, array dimension (lanes per side)
- DW, 32, element width in bits
- DRAIN_CYCLES, 4, zero-input cycles after the last operand before done

Ports:
- clk  input  1  clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  element write strobe
- wr_sel  input  1  0 = matrix A, 1 = matrix B
- wr_row  input  $clog2(N)  element row index
- wr_col  input  $clog2(N)  element column index
- wr_data  input  DW  element value
- start  input  1  begin one stream pass
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse at end of pass
- arr_rst  output  1  accumulator clear to the array
- west_out  output  N*DW  lane i at [i*DW +: DW] feeds inp_west i
- north_out  output  N*DW  lane j at [j*DW +: DW] feeds inp_north j

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset:
  - State goes to IDLE.
  - busy=0, done=0, arr_rst=0, west_out=0, north_out=0.
  - All A/B storage cleared to 0.
  - Reset mid-pass aborts the pass; no done pulse is produced.
- Writes:
  - A write with wr_en=1 stores wr_data at [wr_row][wr_col] of the selected matrix on the next edge.
  - Writes in IDLE are always accepted.
  - Writes while busy are ignored (without macro).
- States: IDLE -> CLR -> STREAM -> DRAIN -> FIN -> IDLE.
  - IDLE: start=1 is accepted; next state is CLR. start while busy is ignored.
  - CLR: 1 cycle; arr_rst=1, busy=1, outputs 0.
  - STREAM: step counter t runs 0 to 2N-2 (7 cycles for N=4). All outputs are registered.
    - Lane i of west_out = A[i][t-i] when 0 <= t-i < N, else 0.
    - Lane j of north_out = B[t-j][j] when 0 <= t-j < N, else 0.
  - DRAIN: DRAIN_CYCLES cycles with outputs 0 and busy=1. DRAIN_CYCLES=0 skips directly to FIN.
  - FIN: done=1 for 1 cycle, busy=0; next state is IDLE.
- Timing:
  - start sampled at edge e gives arr_rst at cycle e+1 and stream step t at cycle e+2+t.
  - done occurs at cycle e+2+(2N-1)+DRAIN_CYCLES.
  - start=1 in the FIN cycle is ignored; a new start is accepted from IDLE only.
- Simultaneous wr_en and start in IDLE: the write lands before the pass's first read, so it is included.
- Indices are treated as unsigned and cannot go out of range. Data passes through unmodified.

Optional Feature:
- Macro: SKEW_FEEDER_DBUF_EN
- Defined:
  - A and B each have a shadow bank; all writes go to the shadow bank and are accepted even while busy.
  - Accepting start copies shadow to active in the same edge; streaming reads active only.
  - Writes during a pass affect the next pass only.
- Undefined: single bank; writes while busy are dropped.

Decomposition:
- Package systolic_pkg: N and DW defaults, state enum (IDLE, CLR, STREAM, DRAIN, FIN), sel constants SEL_A=0 and SEL_B=1.
- One sub-module, skew_lane_mux: given lane index, t, and one matrix row/column, returns the element or 0 according to the window rule. Instantiate 2N copies.

Test Plan:
- Load A[r][c]=4r+c+1 and B[r][c]=16+4r+c, then start. Required:
  - arr_rst high one cycle.
  - west_out lane0 = 1,2,3,4,0,0,0.
  - west_out lane3 = 0,0,0,13,14,15,16.
  - north_out lane1 = 0,17,21,25,29,0,0.
  - done exactly at e+2+7+4.
- With the same A/B, pulse start three times during busy -> exactly one pass, a single done pulse, and no restart.
- Assert rst during STREAM at t=3 -> outputs 0 and busy 0 the next cycle, no done, storage reads back 0 on the next pass.
- Write A[0][0]=99 during busy, then run a second pass:
  - macro undefined: lane0 step0 = 1;
  - macro defined: lane0 step0 = 99.
- Set DRAIN_CYCLES=0 and assert wr_en and start together in IDLE (A[2][1]=7) -> west_out lane2 at t=3 is 7, done at e+9.
